// File: rtl/osd_pkg.sv
// Shared types and sizing for the OSD candidate evaluator.
package osd_pkg;

   localparam int OSD_K = 8;
   localparam int OSD_N = 16;
   localparam int OSD_W = 6;

   // Metric width large enough to hold N * (2^W - 1) without overflow.
   function automatic int metric_width(input int w, input int n);
      return w + $clog2(n + 1);
   endfunction

   localparam int OSD_MW = metric_width(OSD_W, OSD_N);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_MASK = 3'd1,
      ENCODE    = 3'd2,
      METRIC    = 3'd3,
      COMPARE   = 3'd4,
      DONE      = 3'd5
   } osd_state_e;

endpackage

// File: rtl/osd_serial_reencoder.sv
// Serial systematic re-encoder: one parity-matrix row folded in per cycle,
// K cycles after i_start. o_done is high during the final iteration.
module osd_serial_reencoder #(
   parameter int K = 8,
   parameter int N = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [K-1:0]       i_info,
   input  logic [K*(N-K)-1:0] i_par_mat,
   output logic [N-K-1:0]     o_parity,
   output logic               o_done
);

   localparam int PW = N - K;
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   logic          r_active;
   logic [IW-1:0] r_idx;
   logic [PW-1:0] r_parity;

   // Row-serial accumulation of parity = info * P over GF(2).
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_active <= 1'b0;
         r_idx    <= '0;
         r_parity <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_idx    <= '0;
         r_parity <= '0;
      end else if (r_active) begin
         if (i_info[r_idx]) begin
            r_parity <= r_parity ^ i_par_mat[r_idx*PW +: PW];
         end
         if (r_idx == IW'(K - 1)) begin
            r_active <= 1'b0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign o_parity = r_parity;
   assign o_done   = r_active & (r_idx == IW'(K - 1));

endmodule

// File: rtl/osd_candidate_evaluator.sv
// OSD candidate evaluator: for each flip mask, re-encode the flipped MRB,
// accumulate the discrepancy metric against the hard decisions and keep
// the lowest-metric codeword of the frame.
module osd_candidate_evaluator
   import osd_pkg::*;
#(
   parameter int K  = OSD_K,
   parameter int N  = OSD_N,
   parameter int W  = OSD_W,
   parameter int MW = metric_width(W, N)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [N-1:0]       i_hard_dec,
   input  logic [N*W-1:0]     i_rel,
   input  logic [K*(N-K)-1:0] i_par_mat,
   input  logic               i_mask_valid,
   input  logic [K-1:0]       i_mask_in,
   input  logic               i_mask_last,
   output logic               o_mask_ready,
   output logic               o_busy,
   output logic               o_best_valid,
   output logic [N-1:0]       o_best_cw,
   output logic [MW-1:0]      o_best_metric
);

   localparam int JW = $clog2(N);

   osd_state_e         r_state;
   osd_state_e         w_next;
   logic [N-1:0]       r_hard_dec;
   logic [N*W-1:0]     r_rel;
   logic [K*(N-K)-1:0] r_par_mat;
   logic [K-1:0]       r_info;
   logic               r_last;
   logic [MW-1:0]      r_metric;
   logic [JW-1:0]      r_j;
   logic               r_mask_ready;
   logic               r_busy;
   logic               r_best_valid;
   logic [N-1:0]       r_best_cw;
   logic [MW-1:0]      r_best_metric;

   logic               w_transfer;
   logic               w_start_ok;
   logic [N-K-1:0]     w_parity;
   logic               w_enc_done;
   logic [N-1:0]       w_cw;
   logic [W-1:0]       w_rel_j;
   logic               w_mismatch;

   assign w_transfer = (r_state == WAIT_MASK) & r_mask_ready & i_mask_valid;
   assign w_start_ok = i_start & ((r_state == IDLE) | (r_state == DONE));
   assign w_cw       = {w_parity, r_info};
   assign w_rel_j    = r_rel[r_j*W +: W];
   assign w_mismatch = w_cw[r_j] ^ r_hard_dec[r_j];

   osd_serial_reencoder #(
      .K (K),
      .N (N)
   ) u_reencoder (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (w_transfer),
      .i_info    (r_info),
      .i_par_mat (r_par_mat),
      .o_parity  (w_parity),
      .o_done    (w_enc_done)
   );

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic for the per-mask evaluation sequence.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_start_ok) begin
               w_next = WAIT_MASK;
            end else begin
               w_next = r_state;
            end
         end
         WAIT_MASK: begin
            if (w_transfer) begin
               w_next = ENCODE;
            end else begin
               w_next = WAIT_MASK;
            end
         end
         ENCODE: begin
            if (w_enc_done) begin
               w_next = METRIC;
            end else begin
               w_next = ENCODE;
            end
         end
         METRIC: begin
            if (r_j == JW'(N - 1)) begin
               w_next = COMPARE;
            end else begin
               w_next = METRIC;
            end
         end
         COMPARE: begin
            if (r_last) begin
               w_next = DONE;
            end else begin
               w_next = WAIT_MASK;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Frame capture, metric accumulation, best-candidate tracking and registered status outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hard_dec    <= '0;
         r_rel         <= '0;
         r_par_mat     <= '0;
         r_info        <= '0;
         r_last        <= 1'b0;
         r_metric      <= '0;
         r_j           <= '0;
         r_mask_ready  <= 1'b0;
         r_busy        <= 1'b0;
         r_best_valid  <= 1'b0;
         r_best_cw     <= '0;
         r_best_metric <= '1;
      end else begin
         r_mask_ready <= (w_next == WAIT_MASK);
         r_busy       <= (w_next != IDLE) && (w_next != DONE);
         r_best_valid <= (w_next == DONE);
         case (r_state)
            IDLE, DONE: begin
               if (w_start_ok) begin
                  r_hard_dec    <= i_hard_dec;
                  r_rel         <= i_rel;
                  r_par_mat     <= i_par_mat;
                  r_best_metric <= '1;
                  r_best_cw     <= '0;
               end
            end
            WAIT_MASK: begin
               if (w_transfer) begin
                  r_info <= r_hard_dec[K-1:0] ^ i_mask_in;
                  r_last <= i_mask_last;
               end
            end
            ENCODE: begin
               if (w_enc_done) begin
                  r_metric <= '0;
                  r_j      <= '0;
               end
            end
            METRIC: begin
               if (w_mismatch) begin
                  r_metric <= r_metric + MW'(w_rel_j);
               end
               r_j <= r_j + 1'b1;
            end
            COMPARE: begin
               // Strict compare: on a tie the earlier candidate is kept.
               if (r_metric < r_best_metric) begin
                  r_best_metric <= r_metric;
                  r_best_cw     <= w_cw;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_mask_ready  = r_mask_ready;
   assign o_busy        = r_busy;
   assign o_best_valid  = r_best_valid;
   assign o_best_cw     = r_best_cw;
   assign o_best_metric = r_best_metric;

endmodule

// File: tb/tb_osd_candidate_evaluator.sv
// Scoreboard bench for osd_candidate_evaluator: directed cases plus random frames,
// checked against a codeword/metric reference model.
module tb_osd_candidate_evaluator;
   import osd_pkg::*;

   localparam int K  = 8;
   localparam int N  = 16;
   localparam int W  = 6;
   localparam int PW = N - K;
   localparam int MW = 11;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [N-1:0]       hd = '0;
   logic [N*W-1:0]     rel = '0;
   logic [K*PW-1:0]    pm = '0;
   logic               mv = 1'b0;
   logic [K-1:0]       mi = '0;
   logic               ml = 1'b0;
   logic               mask_ready, busy, best_valid;
   logic [N-1:0]       best_cw;
   logic [MW-1:0]      best_metric;

   osd_candidate_evaluator dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_hard_dec    (hd),
      .i_rel         (rel),
      .i_par_mat     (pm),
      .i_mask_valid  (mv),
      .i_mask_in     (mi),
      .i_mask_last   (ml),
      .o_mask_ready  (mask_ready),
      .o_busy        (busy),
      .o_best_valid  (best_valid),
      .o_best_cw     (best_cw),
      .o_best_metric (best_metric)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int last_acc = -1000;

   typedef struct {
      logic [N-1:0]  cw;
      logic [MW-1:0] met;
   } exp_t;
   exp_t sb[$];

   // Reference model of the current frame.
   logic [N-1:0]    m_hd;
   logic [N*W-1:0]  m_rel;
   logic [K*PW-1:0] m_pm;
   logic [N-1:0]    m_best_cw;
   int              m_best_met;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Candidate codeword = [info*P | info], metric = sum of rel where it disagrees with hard decisions.
   function automatic void model_cand(input logic [K-1:0] mask, output logic [N-1:0] cw, output int met);
      logic [K-1:0]  info;
      logic [PW-1:0] par;
      info = m_hd[K-1:0] ^ mask;
      for (int c = 0; c < PW; c++) begin
         int ones;
         ones = 0;
         for (int r = 0; r < K; r++) ones += int'(info[r] & m_pm[r*PW + c]);
         par[c] = ones[0];
      end
      cw  = {par, info};
      met = 0;
      for (int j = 0; j < N; j++)
         if (cw[j] != m_hd[j]) met += int'(m_rel[j*W +: W]);
   endfunction

   task automatic do_start(input logic [N-1:0] h, input logic [N*W-1:0] r, input logic [K*PW-1:0] p);
      hd = h; rel = r; pm = p; start = 1'b1;
      m_hd = h; m_rel = r; m_pm = p; m_best_cw = '0; m_best_met = 2047;
      @(negedge clk);
      start = 1'b0;
      check("start_clears_valid", {63'd0, best_valid}, 64'd0);
      check("start_ready", {63'd0, mask_ready}, 64'd1);
   endtask

   task automatic send_mask(input logic [K-1:0] mask, input logic last, input bit hold, input bit gap_chk);
      bit ok;
      logic [N-1:0] cw;
      int met;
      exp_t e;
      mv = 1'b1; mi = mask; ml = last; ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (mask_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL accept_timeout: mask %0h never accepted", mask);
         mv = 1'b0;
      end else begin
         model_cand(mask, cw, met);
         if (met < m_best_met) begin
            m_best_met = met;
            m_best_cw  = cw;
         end
         if (last) begin
            e.cw = m_best_cw; e.met = MW'(m_best_met);
            sb.push_back(e);
         end
         if (gap_chk) check("throughput_gap", 64'(cyc - last_acc), 64'd26);
         last_acc = cyc;
         @(negedge clk);
         if (!hold) mv = 1'b0;
      end
   endtask

   task automatic wait_inter();
      repeat (25) @(negedge clk);
      check("inter_metric", 64'(best_metric), 64'(m_best_met));
      check("inter_cw", 64'(best_cw), 64'(m_best_cw));
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (best_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL done_timeout: best_valid never rose");
      end
   endtask

   // Monitor: pops the scoreboard on each best_valid rise; polices mask_ready spacing.
   initial begin
      logic prev_bv;
      exp_t e;
      int d;
      prev_bv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_bv = 1'b0;
         end else begin
            d = cyc - last_acc;
            if (mask_ready) check("ready_only_in_wait", {63'd0, (d >= 1 && d <= 25)}, 64'd0);
            if (best_valid && !prev_bv) begin
               if (sb.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_best_valid: got 1 expected no result pending");
               end else begin
                  e = sb.pop_front();
                  check("sb_best_cw", 64'(best_cw), 64'(e.cw));
                  check("sb_best_metric", 64'(best_metric), 64'(e.met));
                  check("latency", 64'(d), 64'd26);
                  check("done_not_busy", {63'd0, busy}, 64'd0);
               end
            end
            prev_bv = best_valid;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, {63'd0, mask_ready}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_valid"}, {63'd0, best_valid}, 64'd0);
      check({tag, "_cw"}, 64'(best_cw), 64'd0);
      check({tag, "_metric"}, 64'(best_metric), 64'h7FF);
   endtask

   task automatic test1();
      do_start(16'h0000, {N{6'd1}}, 64'd0);
      send_mask(8'h01, 1'b1, 1'b0, 1'b0);
      wait_done();
      check("t1_cw", 64'(best_cw), 64'h0001);
      check("t1_metric", 64'(best_metric), 64'd1);
   endtask

   initial begin
      logic [N*W-1:0] rr;
      logic [K-1:0]   mk;
      int nm;
      bit hold;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      // 1: single order-1 candidate
      test1();

      // 2: parity row 0 all ones, better second candidate
      do_start(16'h0000, {N{6'd1}}, 64'h00000000000000FF);
      send_mask(8'h01, 1'b0, 1'b0, 1'b0);
      wait_inter();
      check("t2_mid_metric", 64'(best_metric), 64'd9);
      check("t2_mid_cw", 64'(best_cw), 64'hFF01);
      send_mask(8'h02, 1'b1, 1'b0, 1'b0);
      wait_done();
      check("t2_metric", 64'(best_metric), 64'd1);
      check("t2_cw", 64'(best_cw), 64'h0002);

      // 3: tie keeps the earlier candidate
      do_start(16'h0000, {N{6'd1}}, 64'd0);
      send_mask(8'h01, 1'b0, 1'b0, 1'b0);
      send_mask(8'h02, 1'b1, 1'b0, 1'b0);
      wait_done();
      check("t3_cw", 64'(best_cw), 64'h0001);
      check("t3_metric", 64'(best_metric), 64'd1);

      // 4: mask_valid held high -> one transfer every 26 cycles
      do_start(16'h0000, {N{6'd1}}, 64'd0);
      send_mask(8'h01, 1'b0, 1'b1, 1'b0);
      send_mask(8'h02, 1'b0, 1'b1, 1'b1);
      send_mask(8'h04, 1'b1, 1'b0, 1'b1);
      wait_done();
      check("t4_cw", 64'(best_cw), 64'h0001);

      // 5: reset in METRIC of mask 2, then re-run test 1
      do_start(16'h0000, {N{6'd1}}, 64'h00000000000000FF);
      send_mask(8'h01, 1'b0, 1'b0, 1'b0);
      send_mask(8'h02, 1'b1, 1'b0, 1'b0);
      repeat (11) @(negedge clk);
      check("t5_in_frame_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      sb.delete();
      last_acc = -1000;
      @(negedge clk);
      check_reset_vals("t5_rst");
      rst = 1'b0;
      @(negedge clk);
      test1();

      // 6: start while busy is ignored; rel[0]=63
      rr = {N{6'd1}};
      rr[5:0] = 6'd63;
      do_start(16'h0000, rr, 64'd0);
      send_mask(8'h01, 1'b1, 1'b0, 1'b0);
      hd = '1; rel = '0; pm = '1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; hd = '0; rel = rr; pm = '0;
      wait_done();
      check("t6_metric", 64'(best_metric), 64'd63);
      check("t6_cw", 64'(best_cw), 64'h0001);

      // Random frames
      for (int f = 0; f < 25; f++) begin
         for (int j = 0; j < N; j++) rr[j*W +: W] = W'($urandom_range(0, 63));
         do_start(N'($urandom), rr, {32'($urandom), 32'($urandom)});
         nm = $urandom_range(1, 4);
         hold = ($urandom_range(0, 1) == 1);
         for (int m = 0; m < nm; m++) begin
            mk = ($urandom_range(0, 3) == 0) ? 8'h00 : K'($urandom);
            send_mask(mk, (m == nm - 1), hold && (m != nm - 1), hold && (m != 0));
            if (m != nm - 1 && !hold) wait_inter();
         end
         wait_done();
      end

      repeat (3) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
